// File: rtl/if_fetch_stage_pkg.sv
// Pipeline bus widths and the stall-vector encoding shared by the fetch stage and its neighbours.
package if_fetch_stage_pkg;
  localparam int STALL_W     = 6;
  localparam int IF_TO_ID_WD = 33;
  localparam int BR_WD       = 33;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  typedef logic [STALL_W-1:0] stall_bus_t;
endpackage

// File: rtl/if_fetch_stage.sv
// MIPS instruction-fetch stage: owns the PC, drives a request/response instruction SRAM port,
// buffers one returned word across stalls and applies decode redirects after the delay slot.
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  stall_bus_t             stall,
  input  logic [BR_WD-1:0]       br_bus,
  output logic                   inst_req,
  output logic [31:0]            inst_addr,
  input  logic                   inst_addr_ok,
  input  logic                   inst_data_ok,
  input  logic [31:0]            inst_rdata,
  output logic [IF_TO_ID_WD-1:0] if_to_id_bus,
  output logic [31:0]            if_inst,
  output logic                   stallreq,
  output logic [1:0]             o_dbg_state
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;

  logic [1:0]  r_state;
  logic [31:0] r_fetch_pc;
  logic [31:0] r_inst_buf;
  logic        r_pend_valid;
  logic [31:0] r_pend_addr;

  logic        w_br_e;
  logic [31:0] w_br_addr;
  logic        w_no_stop;
  logic        w_avail;
  logic        w_deliver;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_next_pc;
  logic        w_unused_stall;

  assign w_br_e         = br_bus[32];
  assign w_br_addr      = br_bus[31:0];
  assign w_no_stop      = (stall[0] == NO_STOP);
  assign w_unused_stall = ^stall[STALL_W-1:1];

  // SRAM handshake: a request is held (inst_req, inst_addr stable) until inst_addr_ok;
  // exactly one response then follows with inst_data_ok. avail ignores stall to avoid a loop.
  assign w_avail    = ((r_state == S_WAIT) && inst_data_ok) || (r_state == S_HOLD);
  assign w_deliver  = w_avail && w_no_stop;
  assign w_pc_plus4 = r_fetch_pc + 32'd4;
  assign w_next_pc  = r_pend_valid ? r_pend_addr : (w_br_e ? w_br_addr : w_pc_plus4);

  assign inst_req     = (r_state == S_REQ);
  assign inst_addr    = r_fetch_pc;
  assign stallreq     = ~w_avail;
  assign if_to_id_bus = {w_deliver, r_fetch_pc};
  assign if_inst      = !w_deliver           ? 32'd0      :
                        (r_state == S_HOLD) ? r_inst_buf : inst_rdata;
  assign o_dbg_state  = r_state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_fetch_pc   <= RESET_PC;
      r_inst_buf   <= 32'd0;
      r_pend_valid <= 1'b0;
      r_pend_addr  <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: r_state <= S_REQ;
        S_REQ:  if (inst_addr_ok) r_state <= S_WAIT;
        S_WAIT: begin
          if (inst_data_ok) begin
            r_inst_buf <= inst_rdata;
            r_state    <= w_no_stop ? S_REQ : S_HOLD;
          end
        end
        S_HOLD: if (w_no_stop) r_state <= S_REQ;
        default: r_state <= S_IDLE;
      endcase

      // The word being delivered is the delay slot; any redirect seen so far steers the next fetch.
      if (w_deliver) begin
        r_fetch_pc   <= w_next_pc;
        r_pend_valid <= 1'b0;
      end else if (w_br_e) begin
        r_pend_valid <= 1'b1;
        r_pend_addr  <= w_br_addr;
      end
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: scripted SRAM handshakes, decode-side scoreboard on delivered words.
module tb_if_fetch_stage;
  import if_fetch_stage_pkg::*;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_HOLD = 2'd3;

  logic                   clk;
  logic                   rst;
  stall_bus_t             stall;
  logic [BR_WD-1:0]       br_bus;
  logic                   inst_req;
  logic [31:0]            inst_addr;
  logic                   inst_addr_ok;
  logic                   inst_data_ok;
  logic [31:0]            inst_rdata;
  logic [IF_TO_ID_WD-1:0] if_to_id_bus;
  logic [31:0]            if_inst;
  logic                   stallreq;
  logic [1:0]             o_dbg_state;

  int n_total = 0;
  int n_pass  = 0;
  logic [63:0] exp_q[$];
  logic [63:0] mon_exp;

  if_fetch_stage #(.RESET_PC(32'hBFC0_0000)) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .br_bus       (br_bus),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .if_to_id_bus (if_to_id_bus),
    .if_inst      (if_inst),
    .stallreq     (stallreq),
    .o_dbg_state  (o_dbg_state)
  );

  // Clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  // Scoreboard monitor: every delivery must match the oldest expected {pc, inst}
  initial begin
    forever begin
      @(negedge clk);
      if (if_to_id_bus[32] === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_delivery: got pc %h inst %h expected none",
                   if_to_id_bus[31:0], if_inst);
        end else begin
          mon_exp = exp_q.pop_front();
          chk("deliver_pc_inst", {if_to_id_bus[31:0], if_inst}, mon_exp);
        end
      end
    end
  end

  // Driver: one complete fetch, entered just after the edge that put the DUT in REQ.
  task automatic fetch_one(input logic [31:0] addr, input logic [31:0] rdata,
                           input int addr_wait, input int data_delay, input int stop_cycles,
                           input logic br_delay, input logic br_deliv, input logic [31:0] br_addr);
    for (int i = 0; i < addr_wait; i++) begin
      @(negedge clk);
      chk("req_held", {63'd0, inst_req}, 64'd1);
      chk("addr_held", {32'd0, inst_addr}, {32'd0, addr});
      chk("stallreq_in_req", {63'd0, stallreq}, 64'd1);
      @(posedge clk); #1;
    end
    inst_addr_ok = 1'b1;
    @(negedge clk);
    chk("req", {63'd0, inst_req}, 64'd1);
    chk("req_addr", {32'd0, inst_addr}, {32'd0, addr});
    @(posedge clk); #1;
    inst_addr_ok = 1'b0;
    for (int i = 0; i < data_delay; i++) begin
      br_bus = {br_delay, br_addr};
      @(negedge clk);
      chk("wait_stallreq", {63'd0, stallreq}, 64'd1);
      chk("wait_ce", {63'd0, if_to_id_bus[32]}, 64'd0);
      @(posedge clk); #1;
    end
    br_bus       = {br_deliv, br_addr};
    inst_data_ok = 1'b1;
    inst_rdata   = rdata;
    stall[0]     = (stop_cycles > 0) ? STOP : NO_STOP;
    exp_q.push_back({addr, rdata});
    @(negedge clk);
    chk("data_stallreq", {63'd0, stallreq}, 64'd0);
    chk("data_ce", {63'd0, if_to_id_bus[32]}, (stop_cycles == 0) ? 64'd1 : 64'd0);
    @(posedge clk); #1;
    inst_data_ok = 1'b0;
    inst_rdata   = 32'hDEAD_BEEF;
    br_bus       = '0;
    if (stop_cycles > 0) begin
      for (int i = 1; i < stop_cycles; i++) begin
        @(negedge clk);
        chk("hold_state", {62'd0, o_dbg_state}, {62'd0, ST_HOLD});
        chk("hold_stallreq", {63'd0, stallreq}, 64'd0);
        chk("hold_ce", {63'd0, if_to_id_bus[32]}, 64'd0);
        @(posedge clk); #1;
      end
      stall[0] = NO_STOP;
      @(negedge clk);
      chk("release_state", {62'd0, o_dbg_state}, {62'd0, ST_HOLD});
      chk("release_ce", {63'd0, if_to_id_bus[32]}, 64'd1);
      @(posedge clk); #1;
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req"}, {63'd0, inst_req}, 64'd0);
    chk({tag, "_addr"}, {32'd0, inst_addr}, 64'h0000_0000_BFC0_0000);
    chk({tag, "_bus"}, {31'd0, if_to_id_bus}, 64'h0000_0000_BFC0_0000);
    chk({tag, "_inst"}, {32'd0, if_inst}, 64'd0);
    chk({tag, "_stallreq"}, {63'd0, stallreq}, 64'd1);
    chk({tag, "_state"}, {62'd0, o_dbg_state}, {62'd0, ST_IDLE});
  endtask

  // Stimulus
  initial begin
    rst          = 1'b1;
    stall        = '0;
    br_bus       = '0;
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    inst_rdata   = 32'd0;
    #2 rst = 1'b0;
    @(negedge clk);
    chk_reset_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("idle_req", {63'd0, inst_req}, 64'd0);
    chk("idle_stallreq", {63'd0, stallreq}, 64'd1);
    @(posedge clk); #1;

    // Back-to-back fetches; the third is a delay slot with a late response and a branch
    fetch_one(32'hBFC0_0000, 32'h2408_0001, 0, 0, 0, 1'b0, 1'b0, 32'd0);
    fetch_one(32'hBFC0_0004, 32'h2409_0002, 0, 0, 0, 1'b0, 1'b0, 32'd0);
    fetch_one(32'hBFC0_0008, 32'h240A_0003, 0, 1, 0, 1'b1, 1'b0, 32'hBFC0_0100);
    // Slow address acceptance, then a stalled response held in the buffer
    fetch_one(32'hBFC0_0100, 32'h8C0B_0000, 3, 0, 0, 1'b0, 1'b0, 32'd0);
    fetch_one(32'hBFC0_0104, 32'h3C01_1234, 0, 0, 2, 1'b0, 1'b0, 32'd0);
    // Redirect in the delivery cycle itself, then PC wrap-around
    fetch_one(32'hBFC0_0108, 32'h0000_0000, 0, 0, 0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    fetch_one(32'hFFFF_FFFC, 32'h2442_0001, 0, 0, 0, 1'b0, 1'b0, 32'd0);
    fetch_one(32'h0000_0000, 32'h2463_0002, 0, 0, 0, 1'b0, 1'b0, 32'd0);
    fetch_one(32'h0000_0004, 32'h2484_0003, 0, 0, 0, 1'b0, 1'b0, 32'd0);

    // Reset while a response is outstanding
    inst_addr_ok = 1'b1;
    @(negedge clk);
    chk("pre_rst_addr", {32'd0, inst_addr}, 64'h0000_0000_0000_0008);
    @(posedge clk); #1;
    inst_addr_ok = 1'b0;
    @(negedge clk);
    chk("pre_rst_state", {62'd0, o_dbg_state}, {62'd0, ST_WAIT});
    #2 rst = 1'b0;
    #1;
    chk_reset_outputs("async_rst");
    @(posedge clk); #1;
    inst_data_ok = 1'b1;
    inst_rdata   = 32'h0BAD_0BAD;
    @(negedge clk);
    chk("rst_late_ce", {63'd0, if_to_id_bus[32]}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_state", {62'd0, o_dbg_state}, {62'd0, ST_IDLE});
    chk("post_rst_ce", {63'd0, if_to_id_bus[32]}, 64'd0);
    @(posedge clk); #1;
    inst_data_ok = 1'b0;
    fetch_one(32'hBFC0_0000, 32'h2408_0001, 0, 0, 0, 1'b0, 1'b0, 32'd0);
    fetch_one(32'hBFC0_0004, 32'h2409_0002, 0, 0, 1, 1'b0, 1'b0, 32'd0);

    repeat (2) @(negedge clk);
    chk("queue_drained", {32'd0, exp_q.size()}, 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
